// File: rtl/rdoq_quant_param_pipe_if.sv
// Request/result handshake and per-channel config bus for the RDOQ quantisation parameter pipe.
// The DUT uses the slave view. The CU front end and RDOQ core (or a bench) use the master view.
`timescale 1ns/1ps
interface rdoq_quant_param_pipe_if #(
  parameter int NUM_CH  = 3,
  parameter int BD_W    = 5,
  parameter int SIZE_W  = 3,
  parameter int QP_W    = 6,
  parameter int SHIFT_W = 7,
  parameter int QB_W    = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                      cfg_we;
  logic [CH_W-1:0]           cfg_ch;
  logic [BD_W-1:0]           cfg_bit_depth;
  logic [BD_W-1:0]           cfg_max_dr;
  logic                      cfg_ext_prec;

  logic                      in_valid;
  logic                      in_ready;
  logic [CH_W-1:0]           in_ch;
  logic [SIZE_W-1:0]         in_log2_size;
  logic [QP_W-1:0]           in_qp;
  logic                      in_ts;

  logic                      out_valid;
  logic                      out_ready;
  logic [CH_W-1:0]           out_ch;
  logic signed [SHIFT_W-1:0] out_shift;
  logic signed [QB_W-1:0]    out_q_bits;
  logic [15:0]               out_scale;
  logic [3:0]                out_qp_per;
  logic [2:0]                out_qp_rem;
  logic                      out_err;

  modport slave (
    input  cfg_we, cfg_ch, cfg_bit_depth, cfg_max_dr, cfg_ext_prec,
    input  in_valid, in_ch, in_log2_size, in_qp, in_ts,
    output in_ready,
    output out_valid, out_ch, out_shift, out_q_bits, out_scale, out_qp_per, out_qp_rem, out_err,
    input  out_ready
  );

  modport master (
    output cfg_we, cfg_ch, cfg_bit_depth, cfg_max_dr, cfg_ext_prec,
    output in_valid, in_ch, in_log2_size, in_qp, in_ts,
    input  in_ready,
    input  out_valid, out_ch, out_shift, out_q_bits, out_scale, out_qp_per, out_qp_rem, out_err,
    output out_ready
  );
endinterface

// File: rtl/rdoq_quant_param_pipe.sv
// Two-stage valid/ready pipeline that turns a (channel, size, qp, ts) request into RDOQ
// quantisation parameters, using per-channel bit depth / dynamic range / ext-precision config.
`timescale 1ns/1ps
module rdoq_quant_param_pipe #(
  parameter int NUM_CH      = 3,
  parameter int BD_W        = 5,
  parameter int SIZE_W      = 3,
  parameter int QP_W        = 6,
  parameter int SHIFT_W     = 7,
  parameter int QB_W        = 8,
  parameter int QUANT_SHIFT = 14
) (
  input logic clk,
  input logic rst,
  rdoq_quant_param_pipe_if.slave bus
);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MAX_PER = ((1 << QP_W) - 1) / 6;

  logic [BD_W-1:0]   bd_q [NUM_CH];
  logic [BD_W-1:0]   dr_q [NUM_CH];
  logic [NUM_CH-1:0] ep_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        bd_q[i] <= BD_W'(8);
        dr_q[i] <= BD_W'(15);
        ep_q[i] <= 1'b0;
      end
    end else if (bus.cfg_we && (int'(bus.cfg_ch) < NUM_CH)) begin
      bd_q[bus.cfg_ch] <= bus.cfg_bit_depth;
      dr_q[bus.cfg_ch] <= bus.cfg_max_dr;
      ep_q[bus.cfg_ch] <= bus.cfg_ext_prec;
    end
  end

  logic adv1, adv2;
  logic s1_valid, s2_valid;

  assign adv2         = !s2_valid || bus.out_ready;
  assign adv1         = !s1_valid || adv2;
  assign bus.in_ready = adv1;

  // Stage 1 combinational: config snapshot, shift and qp split
  logic                      req_err;
  logic [BD_W-1:0]           sel_bd, sel_dr;
  logic                      sel_ep;
  logic signed [SHIFT_W-1:0] raw_c, shift_c;
  logic [3:0]                per_c;
  logic [2:0]                rem_c;

  always_comb begin
    req_err = int'(bus.in_ch) >= NUM_CH;
    sel_bd  = '0;
    sel_dr  = '0;
    sel_ep  = 1'b0;
    if (!req_err) begin
      sel_bd = bd_q[bus.in_ch];
      sel_dr = dr_q[bus.in_ch];
      sel_ep = ep_q[bus.in_ch];
    end
    raw_c   = SHIFT_W'(sel_dr) - SHIFT_W'(sel_bd) - SHIFT_W'(bus.in_log2_size);
    shift_c = (bus.in_ts && sel_ep && raw_c[SHIFT_W-1]) ? '0 : raw_c;
    // qp/6 as a count of crossed multiples of 6; avoids a divider
    per_c = '0;
    for (int k = 1; k <= MAX_PER; k++) begin
      if (int'(bus.in_qp) >= 6 * k) per_c = 4'(k);
    end
    rem_c = 3'(int'(bus.in_qp) - 6 * int'(per_c));
    if (req_err) begin
      shift_c = '0;
      per_c   = '0;
      rem_c   = '0;
    end
  end

  logic [CH_W-1:0]           s1_ch;
  logic                      s1_err;
  logic signed [SHIFT_W-1:0] s1_shift;
  logic [3:0]                s1_per;
  logic [2:0]                s1_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_err   <= 1'b0;
      s1_shift <= '0;
      s1_per   <= '0;
      s1_rem   <= '0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_ch    <= bus.in_ch;
        s1_err   <= req_err;
        s1_shift <= shift_c;
        s1_per   <= per_c;
        s1_rem   <= rem_c;
      end
    end
  end

  // Stage 2 combinational: q_bits and scale
  logic signed [QB_W-1:0] q_bits_c;
  logic [15:0]            scale_c;

  always_comb begin
    q_bits_c = QB_W'(QUANT_SHIFT) + QB_W'(s1_per)
             + {{(QB_W-SHIFT_W){s1_shift[SHIFT_W-1]}}, s1_shift};
    case (s1_rem)
      3'd0:    scale_c = 16'd26214;
      3'd1:    scale_c = 16'd23302;
      3'd2:    scale_c = 16'd20560;
      3'd3:    scale_c = 16'd18396;
      3'd4:    scale_c = 16'd16384;
      3'd5:    scale_c = 16'd14564;
      default: scale_c = 16'd0;
    endcase
    if (s1_err) begin
      q_bits_c = '0;
      scale_c  = '0;
    end
  end

  logic [CH_W-1:0]           s2_ch;
  logic                      s2_err;
  logic signed [SHIFT_W-1:0] s2_shift;
  logic signed [QB_W-1:0]    s2_q_bits;
  logic [15:0]               s2_scale;
  logic [3:0]                s2_per;
  logic [2:0]                s2_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_ch     <= '0;
      s2_err    <= 1'b0;
      s2_shift  <= '0;
      s2_q_bits <= '0;
      s2_scale  <= '0;
      s2_per    <= '0;
      s2_rem    <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ch     <= s1_ch;
        s2_err    <= s1_err;
        s2_shift  <= s1_shift;
        s2_q_bits <= q_bits_c;
        s2_scale  <= scale_c;
        s2_per    <= s1_per;
        s2_rem    <= s1_rem;
      end
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_ch     = s2_ch;
  assign bus.out_err    = s2_err;
  assign bus.out_shift  = s2_shift;
  assign bus.out_q_bits = s2_q_bits;
  assign bus.out_scale  = s2_scale;
  assign bus.out_qp_per = s2_per;
  assign bus.out_qp_rem = s2_rem;
endmodule

// File: tb/tb_rdoq_quant_param_pipe.sv
// Scoreboard bench for rdoq_quant_param_pipe: a reference model predicts each accepted request,
// and results are compared in order as they leave the pipe.
`timescale 1ns/1ps
module tb_rdoq_quant_param_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rdoq_quant_param_pipe_if bus ();
  rdoq_quant_param_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int ch; int err; int shift; int qbits; int scale; int per; int rem;
  } res_t;

  int   n_vec = 0;
  int   n_err = 0;
  res_t exp_q[$];
  res_t got_q[$];
  int   m_bd[3] = '{8, 8, 8};
  int   m_dr[3] = '{15, 15, 15};
  bit   m_ep[3] = '{0, 0, 0};
  int   scale_tbl[6] = '{26214, 23302, 20560, 18396, 16384, 14564};
  bit   rand_bp = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic res_t model(input int ch, input int size, input int qp, input bit ts);
    res_t r;
    int   raw;
    r = '{ch, 0, 0, 0, 0, 0, 0};
    if (ch >= 3) begin
      r.err = 1;
      return r;
    end
    raw = m_dr[ch] - m_bd[ch] - size;
    if (ts && m_ep[ch] && raw < 0) raw = 0;
    r.shift = raw;
    r.per   = qp / 6;
    r.rem   = qp % 6;
    r.scale = scale_tbl[r.rem];
    r.qbits = 14 + r.per + raw;
    return r;
  endfunction

  always @(negedge clk) begin
    res_t g, e;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
        m_bd[i] = 8; m_dr[i] = 15; m_ep[i] = 1'b0;
      end
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        g.ch = int'(bus.out_ch);   g.err = int'(bus.out_err);
        g.shift = int'(bus.out_shift); g.qbits = int'(bus.out_q_bits);
        g.scale = int'(bus.out_scale); g.per = int'(bus.out_qp_per);
        g.rem = int'(bus.out_qp_rem);
        got_q.push_back(g);
        if (exp_q.size() == 0) chk("unexpected_out", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("sb_ch", g.ch, e.ch);       chk("sb_err", g.err, e.err);
          chk("sb_shift", g.shift, e.shift); chk("sb_qbits", g.qbits, e.qbits);
          chk("sb_scale", g.scale, e.scale); chk("sb_per", g.per, e.per);
          chk("sb_rem", g.rem, e.rem);
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(int'(bus.in_ch), int'(bus.in_log2_size), int'(bus.in_qp), bus.in_ts));
      if (bus.cfg_we && int'(bus.cfg_ch) < 3) begin
        m_bd[bus.cfg_ch] = int'(bus.cfg_bit_depth);
        m_dr[bus.cfg_ch] = int'(bus.cfg_max_dr);
        m_ep[bus.cfg_ch] = bus.cfg_ext_prec;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input int ch, input int size, input int qp, input bit ts);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_ch = 2'(ch); bus.in_log2_size = 3'(size); bus.in_qp = 6'(qp); bus.in_ts = ts;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int bd, input int dr, input bit ep);
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'(ch);
    bus.cfg_bit_depth = 5'(bd); bus.cfg_max_dr = 5'(dr); bus.cfg_ext_prec = ep;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_we = 0; bus.cfg_ch = 0; bus.cfg_bit_depth = 0; bus.cfg_max_dr = 0; bus.cfg_ext_prec = 0;
    bus.in_valid = 0; bus.in_ch = 0; bus.in_log2_size = 0; bus.in_qp = 0; bus.in_ts = 0;
    bus.out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_shift", int'(bus.out_shift), 0);
    chk("rst_qbits", int'(bus.out_q_bits), 0);
    chk("rst_scale", int'(bus.out_scale), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // defaults and latency
    got_q.delete();
    send(0, 2, 22, 0);
    @(negedge clk); chk("lat_c1_valid", int'(bus.out_valid), 0);
    @(negedge clk); chk("lat_c2_valid", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    wait_drain();
    chk("t1_count", got_q.size(), 1);
    chk("t1_shift", got_q[0].shift, 5);   chk("t1_per", got_q[0].per, 3);
    chk("t1_rem", got_q[0].rem, 4);       chk("t1_scale", got_q[0].scale, 16384);
    chk("t1_qbits", got_q[0].qbits, 22);

    // ext precision clamp
    got_q.delete();
    cfg_write(1, 12, 15, 1);
    send(1, 5, 30, 0);
    send(1, 5, 30, 1);
    cfg_write(1, 12, 15, 0);
    send(1, 5, 30, 1);
    wait_drain();
    chk("t2_count", got_q.size(), 3);
    chk("t2a_shift", got_q[0].shift, -2); chk("t2a_qbits", got_q[0].qbits, 17);
    chk("t2a_per", got_q[0].per, 5);      chk("t2a_rem", got_q[0].rem, 0);
    chk("t2a_scale", got_q[0].scale, 26214);
    chk("t2b_shift", got_q[1].shift, 0);  chk("t2b_qbits", got_q[1].qbits, 19);
    chk("t2c_shift", got_q[2].shift, -2); chk("t2c_qbits", got_q[2].qbits, 17);

    // backpressure
    got_q.delete();
    bus.out_ready = 1'b0;
    send(0, 2, 22, 0);
    send(0, 3, 10, 0);
    bus.in_valid = 1'b1; bus.in_ch = 2'd0; bus.in_log2_size = 3'd1; bus.in_qp = 6'd40; bus.in_ts = 1'b0;
    @(negedge clk); chk("stall_ready", int'(bus.in_ready), 0);
    @(negedge clk); chk("stall_valid", int'(bus.out_valid), 1);
    chk("stall_hold_shift", int'(bus.out_shift), 5);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk); chk("rel0_valid", int'(bus.out_valid), 1); chk("rel0_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk); chk("rel1_valid", int'(bus.out_valid), 1);
    @(negedge clk); chk("rel2_valid", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    wait_drain();
    chk("t3_count", got_q.size(), 3);
    chk("t3_order0", got_q[0].shift, 5);
    chk("t3_order1", got_q[1].shift, 4);
    chk("t3_order2", got_q[2].shift, 6);

    // config on the accept edge, error channel, qp boundaries
    got_q.delete();
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_bit_depth = 5'd10; bus.cfg_max_dr = 5'd15; bus.cfg_ext_prec = 1'b0;
    send(0, 2, 22, 0);
    bus.cfg_we = 1'b0;
    send(0, 2, 22, 0);
    send(3, 2, 22, 0);
    send(0, 2, 0, 0);
    send(0, 2, 63, 0);
    cfg_write(3, 20, 1, 1);
    send(0, 2, 22, 0);
    wait_drain();
    chk("t4_count", got_q.size(), 6);
    chk("t4_old_cfg", got_q[0].shift, 5);
    chk("t4_new_cfg", got_q[1].shift, 3);
    chk("t4_err", got_q[2].err, 1);       chk("t4_err_shift", got_q[2].shift, 0);
    chk("t4_err_qbits", got_q[2].qbits, 0); chk("t4_err_scale", got_q[2].scale, 0);
    chk("t4_err_per", got_q[2].per, 0);
    chk("qp0_per", got_q[3].per, 0);      chk("qp0_rem", got_q[3].rem, 0);
    chk("qp63_per", got_q[4].per, 10);    chk("qp63_rem", got_q[4].rem, 3);
    chk("qp63_scale", got_q[4].scale, 18396); chk("qp63_qbits", got_q[4].qbits, 27);
    chk("bad_cfg_ignored", got_q[5].shift, 3);

    // random traffic with random backpressure
    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        cfg_write($urandom_range(0, 3), $urandom_range(8, 16), $urandom_range(10, 20), 1'($urandom_range(0, 1)));
      send($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 63), 1'($urandom_range(0, 1)));
    end
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();

    // reset mid-flight restores defaults
    cfg_write(0, 10, 15, 0);
    got_q.delete();
    send(0, 2, 22, 0);
    send(0, 3, 22, 0);
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(0, 2, 22, 0);
    wait_drain();
    chk("t6_count", got_q.size(), 1);
    chk("t6_shift", got_q[got_q.size()-1].shift, 5);

    chk("final_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
